// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared types and constants for the instruction fetch front end
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with flush; pointers carry an extra wrap bit
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : IF stage - PC ownership, credit-limited imem requests,
//               instruction buffering and redirect squashing
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [XLEN-1:0]  imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [XLEN-1:0]  imem_rsp_data_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             stall_i,
    output logic             if_valid_o,
    output logic [XLEN-1:0]  if_instr_o,
    output logic [XLEN-1:0]  if_pc_o,
    output logic [XLEN-1:0]  if_pc_plus4_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   C_DEPTH = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     in_use;
    logic            tag_full;
    logic            tag_empty;
    logic            buf_full;
    logic            buf_empty;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    buf_head;

    logic            req_fire;
    logic            rsp_keep;
    logic            consume;

    // Every outstanding request owns a buffer slot, so the buffer never overflows.
    assign in_use           = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid_o = reset_i && !redirect_valid_i && !tag_full &&
                              (in_use < C_DEPTH);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_keep  = imem_rsp_valid_i && !tag_empty && !buf_full &&
                       (drop_q == '0) && !redirect_valid_i;
    assign consume   = !buf_empty && !stall_i && !redirect_valid_i;
    assign rsp_entry = '{pc: tag_head, instr: imem_rsp_data_i};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // On redirect, every request still in flight after this edge is stale.
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid_i) begin
            drop_d = outstanding - {{(CW-1){1'b0}}, imem_rsp_valid_i};
        end else if (imem_rsp_valid_i && (drop_q != '0)) begin
            drop_d = drop_q - C_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_rsp_valid_i),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (rsp_keep),
        .push_data_i (rsp_entry),
        .pop_i       (consume),
        .flush_i     (redirect_valid_i),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign if_valid_o    = !buf_empty;
    assign if_instr_o    = if_valid_o ? buf_head.instr : NOP_INSTR;
    assign if_pc_o       = if_valid_o ? buf_head.pc : '0;
    assign if_pc_plus4_o = if_valid_o ? (buf_head.pc + 32'd4) : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed + randomized bench for fetch_stage with an
//                  in-order memory model and an expected-stream reference
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_pc_plus4_o    (if_pc_plus4_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          last_due   = -1;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          accepts    = 0;
    int          consumed   = 0;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_out_pc;
    bit          prev_rd    = 1'b0;
    bit          prev_wait  = 1'b0;
    logic [31:0] prev_addr  = '0;
    bit          obs_req_valid;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at edge+1, check mid-cycle, update the model, advance.
    task automatic cycle(input bit rd, input logic [31:0] tgt, input bit st, input bit rdy);
        bit rsp;
        int due;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? mem_word(mq[0].addr) : $urandom;
        redirect_valid_i = rd;
        redirect_pc_i    = tgt;
        stall_i          = st;
        imem_req_ready_i = rdy;
        #4;
        obs_req_valid = imem_req_valid_o;
        obs_addr      = imem_req_addr_o;

        if (rd)      chk("req_valid_in_redirect", 32'(imem_req_valid_o), 32'd0);
        if (prev_rd) chk("valid_after_redirect", 32'(if_valid_o), 32'd0);
        if (prev_wait && !rd) begin
            chk("req_hold_valid", 32'(imem_req_valid_o), 32'd1);
            chk("req_hold_addr", imem_req_addr_o, prev_addr);
        end
        if (imem_req_valid_o) chk("req_addr", imem_req_addr_o, exp_req_pc);
        if (if_valid_o) begin
            chk("out_pc", if_pc_o, exp_out_pc);
            chk("out_instr", if_instr_o, mem_word(exp_out_pc));
            chk("out_pc_plus4", if_pc_plus4_o, exp_out_pc + 32'd4);
            if (!st && !rd) begin
                exp_out_pc = exp_out_pc + 32'd4;
                consumed++;
            end
        end else begin
            chk("nop_when_invalid", if_instr_o, NOP);
        end

        prev_wait = imem_req_valid_o && !rdy;
        prev_addr = imem_req_addr_o;
        prev_rd   = rd;
        if (imem_req_valid_o && rdy) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{imem_req_addr_o, due});
            exp_req_pc = exp_req_pc + 32'd4;
            accepts++;
        end
        if (rsp) void'(mq.pop_front());
        if (rd) begin
            exp_req_pc = {tgt[31:2], 2'b00};
            exp_out_pc = {tgt[31:2], 2'b00};
        end
        chk("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, 32'(if_valid_o), 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
        chk({tag, "_instr"}, if_instr_o, NOP);
        chk({tag, "_pc"}, if_pc_o, 32'd0);
        chk({tag, "_pc_plus4"}, if_pc_plus4_o, 32'd0);
    endtask

    initial begin
        int          n;
        int          out0;
        int          a0;
        logic [31:0] hold_addr;

        reset_i          = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        stall_i          = 1'b0;
        exp_req_pc       = RESET_PC;
        exp_out_pc       = RESET_PC;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_i = 1'b1;

        // Streaming from RESET_PC, ready high, one-cycle latency.
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("first_req_valid", 32'(obs_req_valid), 32'd1);
        chk("first_req_addr", obs_addr, RESET_PC);
        n = 0;
        while (!(if_valid_o && if_pc_o == RESET_PC + 32'd4) && n < 20) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("reach_pc_104", 32'(n < 20), 32'd1);

        // Stall five cycles while 0x104 is presented.
        out0 = mq.size();
        a0   = accepts;
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("stall_accepts", 32'(accepts - a0), 32'(DEPTH - 1 - out0));
        chk("stall_hold_pc", if_pc_o, RESET_PC + 32'd4);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);

        // Redirect with DEPTH requests in flight; slow memory keeps them pending.
        lat_min = 3;
        lat_max = 3;
        cycle(1'b1, 32'h0000_1000, 1'b0, 1'b1);
        n = 0;
        while (mq.size() != DEPTH && n < 20) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("reach_two_outstanding", 32'(mq.size()), 32'(DEPTH));
        cycle(1'b1, 32'h0000_2002, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("redirect_req_addr", obs_addr, 32'h0000_2000);
        n = 0;
        while (!if_valid_o && n < 30) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("redirect_first_pc", if_pc_o, 32'h0000_2000);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);

        // Memory not ready for four cycles with a request pending.
        lat_min = 1;
        lat_max = 1;
        n = 0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        while (!obs_req_valid && n < 20) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        hold_addr = obs_addr;
        repeat (4) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            chk("notready_valid", 32'(obs_req_valid), 32'd1);
            chk("notready_addr", obs_addr, hold_addr);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("notready_accept_addr", obs_addr, hold_addr);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);

        // Redirect + stall with a response landing in the same cycle.
        n = 0;
        while (!(if_valid_o && mq.size() > 0 && mq[0].due <= cyc) && n < 20) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            n++;
        end
        chk("reach_rsp_collision", 32'(n < 20), 32'd1);
        cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1);
        chk("collision_valid_next", 32'(if_valid_o), 32'd0);
        n = 0;
        while (!if_valid_o && n < 30) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("collision_first_pc", if_pc_o, 32'h0000_4000);

        // PC and PC+4 wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF9, 1'b0, 1'b1);
        repeat (14) cycle(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic.
        lat_min = 1;
        lat_max = 4;
        repeat (400) begin
            cycle($urandom_range(99) < 6, $urandom, $urandom_range(99) < 30,
                  $urandom_range(99) < 75);
        end

        // Asynchronous reset between edges in the middle of a stream.
        lat_min = 1;
        lat_max = 1;
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        last_due  = -1;
        prev_rd   = 1'b0;
        prev_wait = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i    = 1'b1;
        exp_req_pc = RESET_PC;
        exp_out_pc = RESET_PC;
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("post_reset_req_valid", 32'(obs_req_valid), 32'd1);
        chk("post_reset_req_addr", obs_addr, RESET_PC);
        repeat (10) cycle(1'b0, '0, 1'b0, 1'b1);

        chk("overall_progress", 32'(consumed > 60), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch (IF) stage; sits directly upstream of the decode stage and produces the 32-bit instruction word it consumes, plus PC and PC+4.
- Owns the PC register and issues in-order requests to the instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions so a decode stall never drops a fetched word.
- Handles redirects from branches and jumps, discarding in-flight and buffered stale instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries; also the maximum outstanding memory requests (power of 2, at least 2).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts the request this cycle.
- imem_req_addr_o  output  32  fetch address; always equals the current PC, bits[1:0] = 0.
- imem_rsp_valid_i  input  1  response valid; in order, minimum 1 cycle after acceptance, never stalled.
- imem_rsp_data_i  input  32  instruction word.
- redirect_valid_i  input  1  branch or jump taken; load a new PC.
- redirect_pc_i  input  32  redirect target; bits[1:0] ignored (forced 0).
- stall_i  input  1  decode or hazard stall; hold the current output.
- if_valid_o  output  1  if_instr_o, if_pc_o and if_pc_plus4_o are valid.
- if_instr_o  output  32  instruction to decode; NOP_INSTR when if_valid_o = 0.
- if_pc_o  output  32  PC of if_instr_o.
- if_pc_plus4_o  output  32  if_pc_o + 4, modulo 2^32.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - PC = RESET_PC; outstanding count, drop count and buffer are 0.
  - if_valid_o = 0, if_instr_o = NOP_INSTR, if_pc_o = 0, if_pc_plus4_o = 0, imem_req_valid_o = 0 while reset is asserted.
- Request issue:
  - imem_req_valid_o = 1 when (outstanding + buffer_count) < DEPTH and redirect_valid_i = 0.
  - Acceptance (valid & ready) pushes the PC into the tag queue, increments outstanding, and sets PC <= PC + 4 (wraps at 2^32).
  - imem_req_addr_o holds stable while valid && !ready.
- Response:
  - Pops the tag queue and decrements outstanding.
  - If drop count > 0, the word is discarded and the drop count decrements.
  - Otherwise {pc, instr} is pushed into the buffer.
  - The credit rule guarantees the buffer cannot overflow.
- Output:
  - Driven from the buffer head; if_valid_o = buffer not empty.
  - The head is consumed when if_valid_o && !stall_i.
  - Latency: response in cycle t gives if_valid_o in cycle t+1 (registered buffer, no bypass).
- Stall:
  - With stall_i = 1 the outputs hold.
  - Fetching continues until the credits are exhausted.
- Redirect (priority over stall and issue):
  - PC <= {redirect_pc_i[31:2], 2'b00}; the buffer is flushed.
  - drop count <= outstanding at that edge, counting any response arriving in the same cycle.
  - imem_req_valid_o = 0 in the redirect cycle; the first request to the target issues the next cycle.
  - if_valid_o = 0 in the cycle after the redirect.
- Back-to-back redirects: the later one wins; the drop count accumulates correctly.
- A same-cycle response and consume are both honoured (count unchanged).
- Reset mid-operation: the state clears immediately. Responses still arriving from the memory after reset are not supported; the memory is reset on the same reset_i.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013 (addi x0, x0, 0).
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO parameterised by WIDTH and DEPTH, with push, pop, flush, full, empty and count ports.
  - Instantiated twice: once as the tag queue (32-bit PCs), once as the instruction buffer (fetch_entry_t).
  - Pointer wrap uses an extra MSB.

Test Plan:
- Reset with RESET_PC = 32'h100, ready held at 1, 1-cycle response latency:
  - Requests go to 0x100, 0x104, 0x108 …
  - if_pc_o follows the same sequence; if_pc_plus4_o = if_pc_o + 4.
  - if_instr_o matches memory contents; if_instr_o = 32'h13 before the first valid.
- stall_i held 5 cycles while if_pc_o = 0x104:
  - Outputs hold.
  - Exactly DEPTH-1 further requests are issued (0x108 only, for DEPTH = 2).
  - After release, 0x108 follows 0x104 with no gap or duplicate.
- Redirect to 0x2002 with 2 requests outstanding:
  - Both responses are dropped; the buffer is flushed.
  - The next request address is 0x2000; the next valid if_pc_o is 0x2000.
- imem_req_ready_i low for 4 cycles:
  - imem_req_valid_o stays 1 and imem_req_addr_o stays stable; the PC does not advance.
- redirect_valid_i and stall_i together, with a response arriving the same cycle:
  - The redirect wins and the arriving word is dropped.
  - if_valid_o = 0 in the next cycle.
- reset_i asserted mid-stream, asynchronously between edges:
  - if_valid_o falls to 0 immediately.
  - After release, the first request address is RESET_PC.
